// File: rtl/exc_flush_ctrl_pkg.sv
// Shared definitions for the writeback exception/ERTN sequencer:
// exception codes, cause bit positions and FSM state encoding.
package exc_flush_ctrl_pkg;

  localparam int EXC_W      = 6;
  localparam int ECODE_W    = 6;
  localparam int ESUBCODE_W = 9;

  // Bit positions inside ws_exc
  localparam int EXC_ADEF = 0;
  localparam int EXC_INE  = 1;
  localparam int EXC_SYS  = 2;
  localparam int EXC_BRK  = 3;
  localparam int EXC_ALE  = 4;
  localparam int EXC_ADEM = 5;

  localparam logic [ECODE_W-1:0] ECODE_INT = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_ADE = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE = 6'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE = 6'h0D;

  localparam logic [ESUBCODE_W-1:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [ESUBCODE_W-1:0] ESUBCODE_ADEM = 9'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_DRAIN,
    ST_REDIRECT
  } state_t;

endpackage

// File: rtl/exc_flush_ctrl_prio.sv
// Combinational priority encoder: picks the single winning cause among a
// pending interrupt and the WB instruction's exception bits.
module exc_prio_enc
  import exc_flush_ctrl_pkg::*;
(
  input  logic [EXC_W-1:0]      exc,
  input  logic                  int_pending,
  output logic                  hit,
  output logic [ECODE_W-1:0]    ecode,
  output logic [ESUBCODE_W-1:0] esubcode,
  output logic                  badv_we
);

  // NOTE: every output gets a default before the if-chain so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    hit      = 1'b1;
    ecode    = '0;
    esubcode = '0;
    badv_we  = 1'b0;
    if (int_pending) begin
      ecode = ECODE_INT;
    end else if (exc[EXC_ADEF]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUBCODE_ADEF;
      badv_we  = 1'b1;
    end else if (exc[EXC_INE]) begin
      ecode = ECODE_INE;
    end else if (exc[EXC_SYS]) begin
      ecode = ECODE_SYS;
    end else if (exc[EXC_BRK]) begin
      ecode = ECODE_BRK;
    end else if (exc[EXC_ALE]) begin
      ecode   = ECODE_ALE;
      badv_we = 1'b1;
    end else if (exc[EXC_ADEM]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUBCODE_ADEM;
      badv_we  = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Writeback exception/ERTN sequencer: cancel the WB instruction, pulse the
// CSR commit, hold flush while younger stages drain, then redirect fetch.
module exc_flush_ctrl
  import exc_flush_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ws_valid,
  input  logic [PC_W-1:0]       ws_pc,
  input  logic [EXC_W-1:0]      ws_exc,
  input  logic                  ws_ertn,
  input  logic [PC_W-1:0]       ws_badv,
  input  logic                  int_pending,
  input  logic [PC_W-1:0]       csr_eentry,
  input  logic [PC_W-1:0]       csr_era,
  input  logic                  redirect_ready,
  output logic                  ex_cancel,
  output logic                  flush,
  output logic                  busy,
  output logic                  wb_ex,
  output logic [ECODE_W-1:0]    wb_ecode,
  output logic [ESUBCODE_W-1:0] wb_esubcode,
  output logic [PC_W-1:0]       wb_pc,
  output logic                  wb_badv_we,
  output logic [PC_W-1:0]       wb_badv,
  output logic                  eret_flush,
  output logic                  redirect_valid,
  output logic [PC_W-1:0]       redirect_pc
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_t                  state;
  logic [CNT_W-1:0]        drain_cnt;
  logic                    exc_q;

  logic                    enc_hit;
  logic [ECODE_W-1:0]      enc_ecode;
  logic [ESUBCODE_W-1:0]   enc_esubcode;
  logic                    enc_badv_we;
  logic                    wb_event;

  exc_prio_enc u_prio (
    .exc         (ws_exc),
    .int_pending (int_pending),
    .hit         (enc_hit),
    .ecode       (enc_ecode),
    .esubcode    (enc_esubcode),
    .badv_we     (enc_badv_we)
  );

  assign wb_event  = ws_valid & (enc_hit | ws_ertn);
  assign ex_cancel = wb_event & (state == ST_IDLE);
  assign flush     = ex_cancel | ((state != ST_IDLE) && (state != ST_REDIRECT));
  assign busy      = (state != ST_IDLE);

  // The target is read live so fetch sees the CSR values written at commit.
  assign redirect_pc = redirect_valid ? (exc_q ? csr_eentry : csr_era) : '0;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      drain_cnt      <= '0;
      exc_q          <= 1'b0;
      wb_ex          <= 1'b0;
      wb_ecode       <= '0;
      wb_esubcode    <= '0;
      wb_pc          <= '0;
      wb_badv_we     <= 1'b0;
      wb_badv        <= '0;
      eret_flush     <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wb_event) begin
            // An exception or interrupt always beats a concurrent ERTN.
            state       <= ST_COMMIT;
            exc_q       <= enc_hit;
            wb_ex       <= enc_hit;
            eret_flush  <= ~enc_hit;
            wb_ecode    <= enc_hit ? enc_ecode : '0;
            wb_esubcode <= enc_hit ? enc_esubcode : '0;
            wb_pc       <= ws_pc;
            wb_badv_we  <= enc_hit & enc_badv_we;
            wb_badv     <= (enc_hit & enc_badv_we) ? ws_badv : '0;
          end
        end
        ST_COMMIT: begin
          wb_ex       <= 1'b0;
          eret_flush  <= 1'b0;
          wb_ecode    <= '0;
          wb_esubcode <= '0;
          wb_pc       <= '0;
          wb_badv_we  <= 1'b0;
          wb_badv     <= '0;
          drain_cnt   <= DRAIN_LOAD;
          state       <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_commit_onehot: assert property (@(posedge clk) disable iff (!resetn)
    !(wb_ex && eret_flush));
  a_commit_only_in_commit: assert property (@(posedge clk) disable iff (!resetn)
    (wb_ex || eret_flush) |-> (state == ST_COMMIT));

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Self-checking bench for exc_flush_ctrl: CSR commits go through a
// scoreboard queue, sequencing and redirect are checked per scenario.
module tb_exc_flush_ctrl;

  localparam int PC_W  = 32;
  localparam int DRAIN = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            ws_valid = 1'b0;
  logic [PC_W-1:0] ws_pc = '0;
  logic [5:0]      ws_exc = '0;
  logic            ws_ertn = 1'b0;
  logic [PC_W-1:0] ws_badv = '0;
  logic            int_pending = 1'b0;
  logic [PC_W-1:0] csr_eentry = '0;
  logic [PC_W-1:0] csr_era = '0;
  logic            redirect_ready = 1'b1;

  logic            ex_cancel, flush, busy, wb_ex, wb_badv_we, eret_flush;
  logic [5:0]      wb_ecode;
  logic [8:0]      wb_esubcode;
  logic [PC_W-1:0] wb_pc, wb_badv, redirect_pc;
  logic            redirect_valid;

  exc_flush_ctrl #(.DRAIN_CYCLES(DRAIN), .PC_W(PC_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_valid       (ws_valid),
    .ws_pc          (ws_pc),
    .ws_exc         (ws_exc),
    .ws_ertn        (ws_ertn),
    .ws_badv        (ws_badv),
    .int_pending    (int_pending),
    .csr_eentry     (csr_eentry),
    .csr_era        (csr_era),
    .redirect_ready (redirect_ready),
    .ex_cancel      (ex_cancel),
    .flush          (flush),
    .busy           (busy),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_pc          (wb_pc),
    .wb_badv_we     (wb_badv_we),
    .wb_badv        (wb_badv),
    .eret_flush     (eret_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            is_exc;
    logic [5:0]      ecode;
    logic [8:0]      esub;
    logic [PC_W-1:0] pc;
    logic            badv_we;
    logic [PC_W-1:0] badv;
  } commit_t;

  commit_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic commit_t model(input logic [5:0] exc, input logic intp,
                                    input logic [PC_W-1:0] pc, input logic [PC_W-1:0] badv);
    commit_t c;
    c = '{is_exc: 1'b1, ecode: 6'h00, esub: 9'd0, pc: pc, badv_we: 1'b0, badv: '0};
    if (intp)        c.ecode = 6'h00;
    else if (exc[0]) begin c.ecode = 6'h08; c.badv_we = 1'b1; c.badv = badv; end
    else if (exc[1]) c.ecode = 6'h0D;
    else if (exc[2]) c.ecode = 6'h0B;
    else if (exc[3]) c.ecode = 6'h0C;
    else if (exc[4]) begin c.ecode = 6'h09; c.badv_we = 1'b1; c.badv = badv; end
    else if (exc[5]) begin c.ecode = 6'h08; c.esub = 9'd1; c.badv_we = 1'b1; c.badv = badv; end
    else c.is_exc = 1'b0;
    return c;
  endfunction

  // Scoreboard: each CSR commit pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (wb_ex === 1'b1 || eret_flush === 1'b1) begin
      commit_t e;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected: wb_ex=%b eret_flush=%b ecode=%h", wb_ex, eret_flush, wb_ecode);
      end else begin
        e = sb_q.pop_front();
        if (wb_ex !== e.is_exc || eret_flush !== !e.is_exc ||
            (e.is_exc && (wb_ecode !== e.ecode || wb_esubcode !== e.esub ||
                          wb_pc !== e.pc || wb_badv_we !== e.badv_we ||
                          (e.badv_we && wb_badv !== e.badv)))) begin
          failures++;
          $display("FAIL commit_fields: got ex=%b eret=%b ecode=%h sub=%h pc=%h bwe=%b badv=%h exp ex=%b ecode=%h sub=%h pc=%h bwe=%b badv=%h",
                   wb_ex, eret_flush, wb_ecode, wb_esubcode, wb_pc, wb_badv_we, wb_badv,
                   e.is_exc, e.ecode, e.esub, e.pc, e.badv_we, e.badv);
        end
      end
    end
  end

  // Present one WB event for a single cycle (cycle T); returns just after
  // the edge that starts cycle T+1.
  task automatic send(input logic [PC_W-1:0] pc, input logic [5:0] exc, input logic ertn,
                      input logic [PC_W-1:0] badv, input logic intp);
    @(posedge clk); #1;
    ws_valid = 1'b1; ws_pc = pc; ws_exc = exc; ws_ertn = ertn;
    ws_badv = badv; int_pending = intp;
    @(negedge clk);
    checks++;
    if (ex_cancel !== 1'b1 || flush !== 1'b1) begin
      failures++;
      $display("FAIL ex_cancel_at_T: ex_cancel=%b flush=%b exp 1 1", ex_cancel, flush);
    end
    sb_q.push_back(model(exc, intp, pc, badv));
    @(posedge clk); #1;
    ws_valid = 1'b0; ws_exc = '0; ws_ertn = 1'b0; int_pending = 1'b0;
  endtask

  // Bounded wait for the redirect offer, check its PC, then the return to idle.
  task automatic wait_redirect(input string name, input logic [PC_W-1:0] exp_pc);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (redirect_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_redirect_timeout: no redirect_valid within 20 cycles", name);
    end else if (redirect_pc !== exp_pc) begin
      failures++;
      $display("FAIL %s_redirect_pc: got %h exp %h", name, redirect_pc, exp_pc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_back_idle: busy=%b redirect_valid=%b exp 0 0", name, busy, redirect_valid);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, flush, ex_cancel, wb_ex, eret_flush, redirect_valid, wb_badv_we} !== 7'b0 ||
        wb_ecode !== 6'h0 || wb_pc !== '0 || redirect_pc !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b flush=%b wb_ex=%b eret=%b rv=%b exp all 0",
               busy, flush, wb_ex, eret_flush, redirect_valid);
    end
    resetn = 1'b1;
  endtask

  task automatic test_sys_timing();
    csr_eentry = 32'h1c00_8000;
    redirect_ready = 1'b1;
    send(32'h1c00_0010, 6'b000100, 1'b0, '0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      logic exp_flush, exp_rv;
      @(negedge clk);
      exp_flush = (c <= 1 + DRAIN);
      exp_rv    = (c == 2 + DRAIN);
      checks++;
      if (flush !== exp_flush || redirect_valid !== exp_rv || busy !== 1'b1 ||
          (exp_rv && redirect_pc !== 32'h1c00_8000)) begin
        failures++;
        $display("FAIL sys_cycle_T+%0d: flush=%b rv=%b busy=%b rpc=%h exp flush=%b rv=%b busy=1 rpc=1c008000",
                 c, flush, redirect_valid, busy, redirect_pc, exp_flush, exp_rv);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL sys_idle_after: busy=%b exp 0", busy);
    end
  endtask

  task automatic test_ertn();
    csr_era = 32'h1c00_0020;
    send(32'h1c00_0100, 6'b0, 1'b1, '0, 1'b0);
    wait_redirect("ertn", 32'h1c00_0020);
    // Exception with ERTN set: exception wins, redirect goes to EENTRY.
    send(32'h1c00_0104, 6'b000100, 1'b1, '0, 1'b0);
    wait_redirect("ertn_with_sys", 32'h1c00_8000);
  endtask

  task automatic test_priority();
    send(32'h1c00_0200, 6'b010001, 1'b0, 32'h2000_0001, 1'b1);
    wait_redirect("prio_int", 32'h1c00_8000);
    send(32'h1c00_0204, 6'b010001, 1'b0, 32'h2000_0001, 1'b0);
    wait_redirect("prio_adef", 32'h1c00_8000);
    send(32'h1c00_0208, 6'b001110, 1'b0, '0, 1'b0);
    wait_redirect("prio_ine", 32'h1c00_8000);
    send(32'h1c00_020c, 6'b001000, 1'b0, '0, 1'b0);
    wait_redirect("prio_brk", 32'h1c00_8000);
    send(32'h1c00_0210, 6'b0, 1'b1, '0, 1'b1);
    wait_redirect("prio_int_over_ertn", 32'h1c00_8000);
  endtask

  task automatic test_adem_ale();
    send(32'h1c00_0300, 6'b100000, 1'b0, 32'h1000_0003, 1'b0);
    wait_redirect("adem", 32'h1c00_8000);
    send(32'h1c00_0304, 6'b010000, 1'b0, 32'h1000_0006, 1'b0);
    wait_redirect("ale", 32'h1c00_8000);
  endtask

  task automatic test_backpressure();
    logic [PC_W-1:0] first_pc;
    bit seen = 0;
    redirect_ready = 1'b0;
    send(32'h1c00_0400, 6'b000100, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (redirect_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_redirect_timeout: no redirect_valid within 20 cycles");
    end
    first_pc = redirect_pc;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        ws_valid = 1'b1; ws_exc = 6'b000100; ws_pc = 32'h1c00_0500;
      end
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00_8000 || redirect_pc !== first_pc ||
          busy !== 1'b1 || ex_cancel !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: rv=%b rpc=%h busy=%b ex_cancel=%b exp 1 1c008000 1 0",
                 i, redirect_valid, redirect_pc, busy, ex_cancel);
      end
      @(negedge clk);
      ws_valid = 1'b0; ws_exc = '0;
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: busy=%b rv=%b exp 0 0", busy, redirect_valid);
    end
  endtask

  task automatic test_reset_mid();
    int rv_seen = 0;
    redirect_ready = 1'b1;
    send(32'h1c00_0600, 6'b000100, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b flush=%b rv=%b exp 0 0 0", busy, flush, redirect_valid);
    end
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (redirect_valid === 1'b1 || busy === 1'b1) rv_seen++;
    end
    checks++;
    if (rv_seen != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: %0d active cycles after reset exp 0", rv_seen);
    end
  endtask

  initial begin
    test_reset();
    test_sys_timing();
    test_ertn();
    test_priority();
    test_adem_ale();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected commits never seen exp 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_flush_ctrl.md
Name: exc_flush_ctrl

Overview:
- Writeback-side exception/ERTN sequencer.
- Watches the instruction at WB, prioritises its exception causes and a pending interrupt, then runs a fixed sequence: cancel the instruction, pulse the CSR commit (wb_ex / eret_flush), hold the pipeline flush while younger stages drain, then hand a redirect PC to fetch with a valid/ready handshake.
- Sits between the WB stage, the CSR file and the fetch stage.

Parameters:
- DRAIN_CYCLES, 2, cycles flush stays asserted after the commit cycle (>=1).
- PC_W, 32, PC/address width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- ws_valid  in  1  valid instruction at WB
- ws_pc  in  PC_W  PC of WB instruction
- ws_exc  in  6  cause bits: [0]ADEF [1]INE [2]SYS [3]BRK [4]ALE [5]ADEM
- ws_ertn  in  1  WB instruction is ERTN
- ws_badv  in  PC_W  faulting address for ADEF/ALE/ADEM
- int_pending  in  1  CSR: enabled interrupt pending (CRMD.IE & |(ESTAT.IS & ECFG.LIE))
- csr_eentry  in  PC_W  CSR EENTRY value
- csr_era  in  PC_W  CSR ERA value
- redirect_ready  in  1  fetch accepts redirect
- ex_cancel  out  1  comb: kill RF write of WB instruction this cycle
- flush  out  1  kill all younger stages
- busy  out  1  sequence in progress; WB allowin forced low
- wb_ex  out  1  one-cycle exception commit to CSR
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_pc  out  PC_W  PC written to ERA
- wb_badv_we  out  1  write BADV with wb_badv
- wb_badv  out  PC_W  BADV value
- eret_flush  out  1  one-cycle ERTN commit to CSR
- redirect_valid  out  1  redirect PC offered to fetch
- redirect_pc  out  PC_W  new fetch PC

Behaviour:
- Reset: resetn low at a clk edge -> state IDLE, drain counter 0, all registered outputs 0, capture regs 0. Reset mid-sequence aborts with no further pulses.
- event = ws_valid & (int_pending | |ws_exc | ws_ertn), evaluated only in IDLE.
  - ex_cancel = event & state==IDLE.
  - flush = ex_cancel | (state != IDLE && state != REDIRECT).
  - busy = state != IDLE.
- Priority, highest first:
  - INT: ecode 0x00, sub 0
  - ADEF: 0x08, sub 0, badv_we = 1
  - INE: 0x0D
  - SYS: 0x0B
  - BRK: 0x0C
  - ALE: 0x09, badv_we = 1
  - ADEM: 0x08, sub 1, badv_we = 1
  - ERTN only when no exception or interrupt. Exception with ERTN set: the exception wins, no eret_flush.
- FSM:
  - IDLE: on event, register kind (exc/ertn), ecode, subcode, pc, badv, badv_we; go to COMMIT.
  - COMMIT (1 cycle): wb_ex=1 or eret_flush=1 with registered ecode/subcode/pc/badv; the CSR updates at the end of this cycle. Load drain counter with DRAIN_CYCLES-1; go to DRAIN.
  - DRAIN: flush=1; counter decrements each cycle; at 0 go to REDIRECT.
  - REDIRECT: redirect_valid=1, redirect_pc = exc ? csr_eentry : csr_era, sampled live (post-commit CSR values). Hold until redirect_ready; on valid&ready go to IDLE the next cycle.
- Latency: event at cycle T gives wb_ex at T+1, flush high T..T+1+DRAIN_CYCLES, earliest redirect handshake at T+2+DRAIN_CYCLES.
- All of wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_badv_we, wb_badv and eret_flush are zero outside COMMIT.
- Events while busy are ignored; WB cannot advance because busy drives allowin low.
- Simultaneous causes resolve strictly by the priority list above.
- The counter is $clog2(DRAIN_CYCLES+1) bits and never wraps.

Decomposition:
- Shared package holds:
  - ecode constants ECODE_INT/ADE/ALE/SYS/BRK/INE
  - ESUBCODE_ADEF/ADEM
  - ws_exc bit indices
  - FSM state encoding
- One natural sub-module: exc_prio_enc, a combinational priority encoder from ws_exc and int_pending to {hit, ecode, esubcode, badv_we}.

Test Plan:
- SYS at pc 0x1c000010, eentry 0x1c008000, redirect_ready=1 -> ex_cancel at T; wb_ex at T+1 with ecode 0x0B, wb_pc 0x1c000010; flush through T+3; redirect_pc 0x1c008000 at T+4.
- ERTN, era 0x1c000020 -> eret_flush at T+1, wb_ex=0, redirect_pc 0x1c000020.
- ws_exc = ADEF|ALE with int_pending=1 -> ecode 0x00; repeat with int_pending=0 -> ecode 0x08, sub 0, badv_we=1, wb_badv = ws_badv.
- ADEM alone, badv 0x1000_0003 -> ecode 0x08, sub 1, wb_badv 0x1000_0003; ALE alone -> ecode 0x09, sub 0.
- redirect_ready held low 5 cycles -> redirect_valid and redirect_pc stable for 5 cycles; a second event during this wait is ignored and busy stays 1.
- resetn low during DRAIN -> next cycle state IDLE; flush, busy, redirect_valid = 0; no wb_ex or redirect afterwards.
